// File: rtl/ram_2_port_pipe.sv
// Simple-dual-port table RAM: lane-masked write port, 1- or 2-stage read port,
// selectable read-during-write result and a zeroing sweep after reset.
module ram_2_port_pipe #(
  parameter int WORD_SIZE   = 16,
  parameter int LANE_SIZE   = 8,
  parameter int ADDR_SIZE   = 5,
  parameter int NUM_WORDS   = 32,
  parameter int RD_PIPE     = 1,
  parameter int BYPASS      = 1,
  parameter int INIT_ON_RST = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [ADDR_SIZE-1:0]           wr_addr,
  input  logic [WORD_SIZE/LANE_SIZE-1:0] wr_lane_en,
  input  logic [WORD_SIZE-1:0]           wr_word,
  input  logic                           rd_en,
  input  logic [ADDR_SIZE-1:0]           rd_addr,
  output logic [WORD_SIZE-1:0]           rd_word,
  output logic                           rd_valid,
  output logic                           init_busy,
  output logic                           addr_err
);

  localparam int                   NUM_LANES = WORD_SIZE / LANE_SIZE;
  localparam logic [ADDR_SIZE:0]   DEPTH     = (ADDR_SIZE+1)'(NUM_WORDS);
  localparam logic [ADDR_SIZE-1:0] LAST      = ADDR_SIZE'(NUM_WORDS - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e                 state_q;
  logic [ADDR_SIZE-1:0]   cnt_q;
  logic                   addr_err_q;
  logic [WORD_SIZE-1:0]   mem [NUM_WORDS];

  logic                   run;
  logic                   wr_in_range;
  logic                   rd_in_range;
  logic                   wr_acc;
  logic                   rd_acc;
  logic                   bypass_hit;
  logic [WORD_SIZE-1:0]   rd_data_d;
  logic                   s1_valid_q;
  logic [WORD_SIZE-1:0]   s1_word_q;

  assign run         = (state_q == ST_RUN);
  assign wr_in_range = ({1'b0, wr_addr} < DEPTH);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH);
  assign wr_acc      = run && wr_en;
  assign rd_acc      = run && rd_en;
  assign bypass_hit  = (BYPASS != 0) && wr_acc && wr_in_range && (wr_addr == rd_addr);

  assign init_busy   = (state_q == ST_INIT);
  assign addr_err    = addr_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= (INIT_ON_RST != 0) ? ST_INIT : ST_RUN;
      cnt_q      <= '0;
      addr_err_q <= 1'b0;
    end else begin
      if (state_q == ST_INIT) begin
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == LAST) state_q <= ST_RUN;
      end
      if ((wr_acc && !wr_in_range) || (rd_acc && !rd_in_range)) addr_err_q <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset branch; it is cleared by the sweep so it
  // can still map onto a plain RAM macro.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == ST_INIT) begin
        mem[cnt_q] <= '0;
      end else if (wr_acc && wr_in_range) begin
        for (int i = 0; i < NUM_LANES; i++) begin
          if (wr_lane_en[i]) mem[wr_addr][i*LANE_SIZE +: LANE_SIZE] <= wr_word[i*LANE_SIZE +: LANE_SIZE];
        end
      end
    end
  end

  // Out-of-range reads return zero; a same-address write overlays its enabled lanes.
  always_comb begin
    rd_data_d = '0;
    if (rd_in_range) begin
      rd_data_d = mem[rd_addr];
      for (int i = 0; i < NUM_LANES; i++) begin
        if (bypass_hit && wr_lane_en[i]) rd_data_d[i*LANE_SIZE +: LANE_SIZE] = wr_word[i*LANE_SIZE +: LANE_SIZE];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_word_q  <= '0;
    end else begin
      s1_valid_q <= rd_acc;
      if (rd_acc) s1_word_q <= rd_data_d;
    end
  end

  if (RD_PIPE == 2) begin : g_pipe2
    logic                 s2_valid_q;
    logic [WORD_SIZE-1:0] s2_word_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        s2_valid_q <= 1'b0;
        s2_word_q  <= '0;
      end else begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) s2_word_q <= s1_word_q;
      end
    end

    assign rd_valid = s2_valid_q;
    assign rd_word  = s2_word_q;
  end else begin : g_pipe1
    assign rd_valid = s1_valid_q;
    assign rd_word  = s1_word_q;
  end

endmodule

// File: tb/tb_ram_2_port_pipe.sv
// Bench for ram_2_port_pipe: a default instance and a 20-word, 2-stage, old-data
// instance share stimulus and are checked against a table-level reference model.
module tb_ram_2_port_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [1:0]  wr_lane_en;
  logic [15:0] wr_word;
  logic        rd_en;
  logic [4:0]  rd_addr;

  logic [15:0] rd_word_w   [2];
  logic        rd_valid_w  [2];
  logic        init_busy_w [2];
  logic        addr_err_w  [2];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ram_2_port_pipe u_dflt (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_lane_en(wr_lane_en),
    .wr_word(wr_word), .rd_en(rd_en), .rd_addr(rd_addr), .rd_word(rd_word_w[0]),
    .rd_valid(rd_valid_w[0]), .init_busy(init_busy_w[0]), .addr_err(addr_err_w[0])
  );

  ram_2_port_pipe #(.NUM_WORDS(20), .RD_PIPE(2), .BYPASS(0)) u_alt (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_lane_en(wr_lane_en),
    .wr_word(wr_word), .rd_en(rd_en), .rd_addr(rd_addr), .rd_word(rd_word_w[1]),
    .rd_valid(rd_valid_w[1]), .init_busy(init_busy_w[1]), .addr_err(addr_err_w[1])
  );

  // Reference model: table contents, remaining sweep cycles, sticky error flag,
  // and the read result still in flight for the two-stage instance.
  logic [15:0] m_mem      [2][32];
  int          sweep_left [2];
  logic        m_err      [2];
  logic        exp_valid  [2];
  logic [15:0] exp_word   [2];
  logic        pend_v     [2];
  logic [15:0] pend_w     [2];

  logic [15:0] got_w  [2];
  int          got_n  [2];
  int          got_at [2];

  function automatic int depth(input int k);
    return (k == 0) ? 32 : 20;
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] old_w, input logic [15:0] new_w,
                                        input logic [1:0] m);
    logic [15:0] r;
    r = old_w;
    if (m[0]) r[7:0]  = new_w[7:0];
    if (m[1]) r[15:8] = new_w[15:8];
    return r;
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      logic        nv;
      logic [15:0] nw;
      nv = 1'b0;
      nw = 16'h0;
      if (rst) begin
        sweep_left[k] = depth(k);
        m_err[k]      = 1'b0;
        exp_valid[k]  = 1'b0;
        exp_word[k]   = 16'h0;
        pend_v[k]     = 1'b0;
        pend_w[k]     = 16'h0;
      end else begin
        if (sweep_left[k] > 0) begin
          sweep_left[k]--;
          if (sweep_left[k] == 0) for (int a = 0; a < 32; a++) m_mem[k][a] = 16'h0;
        end else begin
          if (rd_en) begin
            nv = 1'b1;
            if (int'(rd_addr) < depth(k)) begin
              nw = m_mem[k][rd_addr];
              if (k == 0 && wr_en && wr_addr == rd_addr) nw = merge(nw, wr_word, wr_lane_en);
            end else begin
              m_err[k] = 1'b1;
            end
          end
          if (wr_en) begin
            if (int'(wr_addr) < depth(k)) m_mem[k][wr_addr] = merge(m_mem[k][wr_addr], wr_word, wr_lane_en);
            else m_err[k] = 1'b1;
          end
        end
        if (k == 0) begin
          exp_valid[k] = nv;
          if (nv) exp_word[k] = nw;
        end else begin
          exp_valid[k] = pend_v[k];
          if (pend_v[k]) exp_word[k] = pend_w[k];
          pend_v[k] = nv;
          pend_w[k] = nw;
        end
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_addr = 5'd0; wr_lane_en = 2'b00; wr_word = 16'h0;
    rd_en = 1'b0; rd_addr = 5'd0;
  endtask

  task automatic access(input logic we, input logic [4:0] wa, input logic [1:0] m,
                        input logic [15:0] ww, input logic re, input logic [4:0] ra);
    wr_en = we; wr_addr = wa; wr_lane_en = m; wr_word = ww; rd_en = re; rd_addr = ra;
    step();
    idle();
    for (int k = 0; k < 2; k++) begin
      got_n[k] = 0; got_at[k] = -1; got_w[k] = 16'h0;
    end
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 2; k++) begin
        if (rd_valid_w[k] === 1'b1) begin
          got_n[k]++;
          got_w[k] = rd_word_w[k];
          if (got_at[k] < 0) got_at[k] = i;
        end
      end
      step();
    end
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    step();
    step();
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if ({init_busy_w[k], addr_err_w[k], rd_valid_w[k], rd_word_w[k]} !== {1'b1, 1'b0, 1'b0, 16'h0}) begin
        miscompares++;
        $display("FAIL reset u%0d: busy/err/vld/word=%b/%b/%b/%h want 1/0/0/0000",
                 k, init_busy_w[k], addr_err_w[k], rd_valid_w[k], rd_word_w[k]);
      end
    end
  endtask

  task automatic test_sweep();
    int busy_n [2];
    int u0_pulses;
    bit u0_zero;
    rst = 1'b0;
    for (int k = 0; k < 2; k++) busy_n[k] = int'(init_busy_w[k]);
    for (int c = 0; c < 60; c++) begin
      idle();
      if (c < 20) begin
        wr_en = 1'($urandom_range(0, 1)); wr_addr = 5'($urandom_range(0, 31));
        wr_lane_en = 2'b11; wr_word = 16'($urandom);
        rd_en = 1'($urandom_range(0, 1)); rd_addr = 5'($urandom_range(0, 31));
      end
      step();
      for (int k = 0; k < 2; k++) begin
        if (init_busy_w[k] === 1'b1) busy_n[k]++;
        vectors++;
        if ({init_busy_w[k], addr_err_w[k], rd_valid_w[k], rd_word_w[k]} !==
            {(sweep_left[k] > 0), m_err[k], exp_valid[k], exp_word[k]}) begin
          miscompares++;
          $display("FAIL sweep u%0d c%0d: got %b/%b/%b/%h want %b/%b/%b/%h", k, c,
                   init_busy_w[k], addr_err_w[k], rd_valid_w[k], rd_word_w[k],
                   (sweep_left[k] > 0), m_err[k], exp_valid[k], exp_word[k]);
        end
      end
      if (init_busy_w[0] !== 1'b1) break;
    end
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (busy_n[k] !== depth(k)) begin
        miscompares++;
        $display("FAIL sweep_len u%0d: busy cycles %0d want %0d", k, busy_n[k], depth(k));
      end
    end
    u0_pulses = 0;
    u0_zero   = 1'b1;
    for (int a = 0; a < 33; a++) begin
      idle();
      if (a < 32) begin
        rd_en = 1'b1; rd_addr = 5'(a);
      end
      step();
      if (rd_valid_w[0] === 1'b1) begin
        u0_pulses++;
        if (rd_word_w[0] !== 16'h0) u0_zero = 1'b0;
      end
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if ({init_busy_w[k], addr_err_w[k], rd_valid_w[k], rd_word_w[k]} !==
            {(sweep_left[k] > 0), m_err[k], exp_valid[k], exp_word[k]}) begin
          miscompares++;
          $display("FAIL read_sweep u%0d a%0d: got %b/%b/%b/%h want %b/%b/%b/%h", k, a,
                   init_busy_w[k], addr_err_w[k], rd_valid_w[k], rd_word_w[k],
                   (sweep_left[k] > 0), m_err[k], exp_valid[k], exp_word[k]);
        end
      end
    end
    vectors++;
    if (u0_pulses !== 32 || u0_zero !== 1'b1) begin
      miscompares++;
      $display("FAIL cleared_table: pulses %0d zero %0b want 32 1", u0_pulses, u0_zero);
    end
  endtask

  task automatic test_lane_mask();
    access(1'b1, 5'd3, 2'b11, 16'hABCD, 1'b0, 5'd0);
    access(1'b1, 5'd3, 2'b10, 16'h1200, 1'b0, 5'd0);
    access(1'b0, 5'd0, 2'b00, 16'h0, 1'b1, 5'd3);
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (got_n[k] !== 1 || got_w[k] !== 16'h12CD) begin
        miscompares++;
        $display("FAIL lane_mask u%0d: pulses %0d word %h want 1 12cd", k, got_n[k], got_w[k]);
      end
    end
  endtask

  task automatic test_rdw();
    logic [15:0] want [2];
    want[0] = 16'h1122;
    want[1] = 16'h1111;
    access(1'b1, 5'd5, 2'b11, 16'h1111, 1'b0, 5'd0);
    access(1'b1, 5'd5, 2'b01, 16'h2222, 1'b1, 5'd5);
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (got_n[k] !== 1 || got_w[k] !== want[k]) begin
        miscompares++;
        $display("FAIL rdw_same_cycle u%0d: pulses %0d word %h want 1 %h", k, got_n[k], got_w[k], want[k]);
      end
    end
    access(1'b0, 5'd0, 2'b00, 16'h0, 1'b1, 5'd5);
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (got_n[k] !== 1 || got_w[k] !== 16'h1122) begin
        miscompares++;
        $display("FAIL rdw_next_cycle u%0d: pulses %0d word %h want 1 1122", k, got_n[k], got_w[k]);
      end
    end
  endtask

  task automatic test_rd_pipe();
    logic [15:0] wd [4];
    int n1;
    bit ok;
    access(1'b0, 5'd0, 2'b00, 16'h0, 1'b1, 5'd5);
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (got_n[k] !== 1 || got_at[k] !== k) begin
        miscompares++;
        $display("FAIL latency u%0d: pulses %0d at %0d want 1 at %0d", k, got_n[k], got_at[k], k);
      end
    end
    for (int a = 0; a < 4; a++) begin
      wd[a] = 16'($urandom);
      access(1'b1, 5'(8 + a), 2'b11, wd[a], 1'b0, 5'd0);
    end
    n1 = 0;
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      idle();
      if (i < 4) begin
        rd_en = 1'b1; rd_addr = 5'(8 + i);
      end
      step();
      if (rd_valid_w[1] !== ((i >= 1) && (i <= 4))) ok = 1'b0;
      if (rd_valid_w[1] === 1'b1) begin
        if (n1 < 4 && rd_word_w[1] !== wd[n1]) ok = 1'b0;
        n1++;
      end
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if ({init_busy_w[k], addr_err_w[k], rd_valid_w[k], rd_word_w[k]} !==
            {(sweep_left[k] > 0), m_err[k], exp_valid[k], exp_word[k]}) begin
          miscompares++;
          $display("FAIL burst u%0d i%0d: got %b/%b/%b/%h want %b/%b/%b/%h", k, i,
                   init_busy_w[k], addr_err_w[k], rd_valid_w[k], rd_word_w[k],
                   (sweep_left[k] > 0), m_err[k], exp_valid[k], exp_word[k]);
        end
      end
    end
    vectors++;
    if (n1 !== 4 || ok !== 1'b1) begin
      miscompares++;
      $display("FAIL burst_pipe2: pulses %0d ok %0b want 4 1", n1, ok);
    end
  endtask

  task automatic test_addr_err();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 0; c < 60 && init_busy_w[0] === 1'b1; c++) step();
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (addr_err_w[k] !== 1'b0 || init_busy_w[k] !== 1'b0) begin
        miscompares++;
        $display("FAIL err_after_reset u%0d: err %b busy %b want 0 0", k, addr_err_w[k], init_busy_w[k]);
      end
    end
    access(1'b1, 5'd5, 2'b11, 16'h5A5A, 1'b0, 5'd0);
    access(1'b1, 5'd25, 2'b11, 16'hFFFF, 1'b0, 5'd0);
    vectors++;
    if (addr_err_w[1] !== 1'b1 || addr_err_w[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL oob_write_err: u0 %b u1 %b want 0 1", addr_err_w[0], addr_err_w[1]);
    end
    access(1'b0, 5'd0, 2'b00, 16'h0, 1'b1, 5'd25);
    vectors++;
    if (got_n[1] !== 1 || got_w[1] !== 16'h0 || got_w[0] !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL oob_read: u1 pulses %0d word %h u0 word %h want 1 0000 ffff", got_n[1], got_w[1], got_w[0]);
    end
    access(1'b0, 5'd0, 2'b00, 16'h0, 1'b1, 5'd5);
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (got_w[k] !== 16'h5A5A) begin
        miscompares++;
        $display("FAIL oob_no_alias u%0d: word %h want 5a5a", k, got_w[k]);
      end
    end
    for (int c = 0; c < 20; c++) begin
      wr_en = 1'($urandom_range(0, 1)); wr_addr = 5'($urandom_range(0, 19));
      wr_lane_en = 2'($urandom); wr_word = 16'($urandom);
      rd_en = 1'($urandom_range(0, 1)); rd_addr = 5'($urandom_range(0, 19));
      step();
    end
    idle();
    vectors++;
    if (addr_err_w[1] !== 1'b1 || addr_err_w[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL err_sticky: u0 %b u1 %b want 0 1", addr_err_w[0], addr_err_w[1]);
    end
  endtask

  task automatic test_mid_sweep();
    int busy_n [2];
    idle();
    rd_en = 1'b1; rd_addr = 5'd1;
    step();
    idle();
    rst = 1'b1;
    step();
    vectors++;
    if (rd_valid_w[1] !== 1'b0 || addr_err_w[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_cancels_read: vld %b err %b want 0 0", rd_valid_w[1], addr_err_w[1]);
    end
    rst = 1'b0;
    for (int c = 0; c < 10; c++) step();
    rst = 1'b1;
    wr_en = 1'b1; wr_addr = 5'd2; wr_lane_en = 2'b11; wr_word = 16'h7777;
    rd_en = 1'b1; rd_addr = 5'd2;
    step();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) busy_n[k] = int'(init_busy_w[k]);
    for (int c = 0; c < 60; c++) begin
      idle();
      if (c < 20) begin
        wr_en = 1'b1; wr_addr = 5'($urandom_range(20, 31)); wr_lane_en = 2'b11; wr_word = 16'($urandom);
        rd_en = 1'b1; rd_addr = 5'($urandom_range(20, 31));
      end else begin
        wr_en = 1'b1; wr_addr = 5'd3; wr_lane_en = 2'b11; wr_word = 16'hBEEF;
        rd_en = 1'b1; rd_addr = 5'd3;
      end
      step();
      for (int k = 0; k < 2; k++) begin
        if (init_busy_w[k] === 1'b1) busy_n[k]++;
        vectors++;
        if ({init_busy_w[k], addr_err_w[k], rd_valid_w[k], rd_word_w[k]} !==
            {(sweep_left[k] > 0), m_err[k], exp_valid[k], exp_word[k]}) begin
          miscompares++;
          $display("FAIL mid_sweep u%0d c%0d: got %b/%b/%b/%h want %b/%b/%b/%h", k, c,
                   init_busy_w[k], addr_err_w[k], rd_valid_w[k], rd_word_w[k],
                   (sweep_left[k] > 0), m_err[k], exp_valid[k], exp_word[k]);
        end
      end
      if (init_busy_w[0] !== 1'b1) break;
    end
    idle();
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (busy_n[k] !== depth(k)) begin
        miscompares++;
        $display("FAIL restart_len u%0d: busy cycles %0d want %0d", k, busy_n[k], depth(k));
      end
    end
    access(1'b0, 5'd0, 2'b00, 16'h0, 1'b1, 5'd3);
    vectors++;
    if (got_w[0] !== 16'h0 || got_w[1] !== 16'hBEEF || addr_err_w[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL ignored_in_sweep: u0 %h u1 %h u0 err %b want 0000 beef 0", got_w[0], got_w[1], addr_err_w[0]);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      wr_en      = 1'($urandom_range(0, 1));
      rd_en      = 1'($urandom_range(0, 1));
      wr_addr    = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      rd_addr    = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      wr_lane_en = 2'($urandom);
      wr_word    = 16'($urandom);
      step();
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if ({init_busy_w[k], addr_err_w[k], rd_valid_w[k], rd_word_w[k]} !==
            {(sweep_left[k] > 0), m_err[k], exp_valid[k], exp_word[k]}) begin
          miscompares++;
          $display("FAIL random u%0d c%0d: got %b/%b/%b/%h want %b/%b/%b/%h", k, c,
                   init_busy_w[k], addr_err_w[k], rd_valid_w[k], rd_word_w[k],
                   (sweep_left[k] > 0), m_err[k], exp_valid[k], exp_word[k]);
        end
      end
    end
    idle();
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      sweep_left[k] = 0; m_err[k] = 1'b0; exp_valid[k] = 1'b0; exp_word[k] = 16'h0;
      pend_v[k] = 1'b0; pend_w[k] = 16'h0;
      for (int a = 0; a < 32; a++) m_mem[k][a] = 16'h0;
    end
    rst = 1'b1;
    idle();
    test_reset();
    test_sweep();
    test_lane_mask();
    test_rdw();
    test_rd_pipe();
    test_addr_err();
    test_mid_sweep();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
